rr_grant_ctrl16: RTL and testbench

- Round-robin arbiter that shares one 16-way resource between 16 requesters.
- Drives an active-low one-hot grant vector in the same 0:15 ordering and polarity as the team's 4-to-16 decoder outputs.
- Also drives the 4-bit encoded grant index, which can feed a decoder select directly.
- Enforces break-before-make between grants and a bounded grant hold time with timeout reporting.

---
 rtl/rr_grant_ctrl16.sv | 115 +++++++++++
 tb/tb_rr_grant_ctrl16.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl16.sv
// 16-way round-robin arbiter with active-low one-hot grant,
// break-before-make release cycle and bounded grant hold time.
module rr_grant_ctrl16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        done,
  output logic [0:15] gnt_n,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [0:15] gnt_n_q, gnt_n_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        tmo_q, tmo_d;

  logic [3:0]  pick;
  logic [3:0]  cand;
  logic        found;

  // first requester at or after ptr, wrapping mod 16
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_n_d = gnt_n_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d       = GRANT;
          idx_d         = pick;
          gnt_n_d       = '1;
          gnt_n_d[pick] = 1'b0;
          valid_d       = 1'b1;
          cnt_d         = '0;
        end
      end
      GRANT: begin
        if (!en || done || !req[idx_q] || cnt_q == HOLD_LAST) begin
          tmo_d   = en && !done && req[idx_q];
          state_d = RELEASE;
          gnt_n_d = '1;
          valid_d = 1'b0;
          ptr_d   = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_n_q <= '1;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_n_q <= gnt_n_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt_n     = gnt_n_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_grant_ctrl16.sv
// Directed bench for rr_grant_ctrl16: reset, single grant,
// round robin, wrap, hold timeout, disable and async reset.
module tb_rr_grant_ctrl16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic [0:15] gnt_n;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int n_cmp;
  int n_err;

  rr_grant_ctrl16 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:15] one_cold(input int idx);
    logic [0:15] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, "_gnt"}, 32'(gnt_n), 32'(one_cold(idx)));
    chk({tag, "_vld"}, 32'(gnt_valid), 32'd1);
  endtask

  task automatic chk_free(input string tag, input logic tmo);
    chk({tag, "_gnt"}, 32'(gnt_n), 32'hFFFF);
    chk({tag, "_vld"}, 32'(gnt_valid), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout), 32'(tmo));
  endtask

  initial begin
    int rr_exp [4];
    rr_exp = '{3, 12, 3, 12};
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    req    = 16'hFFFF;
    done   = 1'b0;

    // reset held with everyone requesting
    tick();
    tick();
    chk_free("rst", 1'b0);
    chk("rst_idx", 32'(gnt_idx), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_grant("first", 0);
    req = 16'h0000;
    tick();
    chk_free("first_rel", 1'b0);
    tick();

    // single requester, done on 3rd grant cycle
    req = 16'h0020;
    tick();
    chk("single_gnt", 32'(gnt_n), 32'(16'b1111_1011_1111_1111));
    chk_grant("single", 5);
    tick();
    chk("single_c2", 32'(gnt_valid), 32'd1);
    tick();
    chk("single_c3", 32'(gnt_valid), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0000;
    chk_free("single_rel", 1'b0);
    chk("single_hold_idx", 32'(gnt_idx), 32'd5);
    tick();

    // round robin from ptr 0 between 3 and 12
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req   = 16'h1008;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_grant("rr", rr_exp[i]);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_free("rr_rel", 1'b0);
      tick();
      chk("rr_gap", 32'(gnt_valid), 32'd0);
    end

    // wrap: 15 then 0 then 15
    req = 16'h8001;
    tick();
    chk_grant("wrap_a", 15);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    chk_grant("wrap_b", 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    chk_grant("wrap_c", 15);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0000;
    tick();

    // hold limit timeout, then lone requester re-granted
    req = 16'h0200;
    tick();
    chk_grant("tmo", 9);
    for (int i = 0; i < 8; i++) begin
      chk("tmo_vld", 32'(gnt_valid), 32'd1);
      chk("tmo_low", 32'(timeout), 32'd0);
      tick();
    end
    chk_free("tmo_rel", 1'b1);
    tick();
    chk_free("tmo_idle", 1'b0);
    tick();
    chk_grant("tmo_regrant", 9);

    // drop enable mid-grant
    en = 1'b0;
    tick();
    chk_free("dis_rel", 1'b0);
    en = 1'b1;
    tick();
    tick();
    chk_grant("dis_regrant", 9);

    // async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_free("areset", 1'b0);
    chk("areset_idx", 32'(gnt_idx), 32'd0);
    req = 16'h8200;
    tick();
    rst_n = 1'b1;
    tick();
    chk_grant("ptr_reset", 9);

    // done coincides with the hold limit: normal release
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    chk("edge_vld", 32'(gnt_valid), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0000;
    chk_free("done_tmo", 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
